// File: rtl/bus_fabric.sv
// Single-master memory-mapped interconnect: base/mask decode, registered one-cycle
// slave strobes, outstanding-read tracking with timeout and unmapped-access errors.
module bus_fabric #(
    parameter int                      AW       = 16,
    parameter int                      DW       = 32,
    parameter int                      N_SLAVES = 4,
    parameter logic [N_SLAVES*AW-1:0]  BASE     = '0,
    parameter logic [N_SLAVES*AW-1:0]  MASK     = '0,
    parameter int                      TIMEOUT  = 255,
    parameter logic [DW-1:0]           ERR_DATA = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AW-1:0]          m_addr,
    input  logic                   m_rd_en,
    input  logic                   m_wr_en,
    input  logic [DW-1:0]          m_wr_data,
    input  logic [DW/8-1:0]        m_wr_mask,
    output logic [DW-1:0]          m_rd_data,
    output logic                   m_rd_valid,
    output logic                   m_busy,
    output logic                   m_err,
    output logic [AW-1:0]          s_addr,
    output logic [DW-1:0]          s_wr_data,
    output logic [DW/8-1:0]        s_wr_mask,
    output logic [N_SLAVES-1:0]    s_rd_en,
    output logic [N_SLAVES-1:0]    s_wr_en,
    input  logic [N_SLAVES*DW-1:0] s_rd_data,
    input  logic [N_SLAVES-1:0]    s_rd_valid
);

    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int MW = DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } state_t;

    state_t                 state_q;
    logic [SW-1:0]          sel_q;
    logic                   isRd_q;
    logic [15:0]            timeoutCnt_q;
    logic [15:0]            timeoutCnt_d;
    logic [AW-1:0]          sAddr_q;
    logic [DW-1:0]          sWrData_q;
    logic [MW-1:0]          sWrMask_q;
    logic [N_SLAVES-1:0]    sRdEn_q;
    logic [N_SLAVES-1:0]    sWrEn_q;
    logic [DW-1:0]          mRdData_q;
    logic                   mRdValid_q;
    logic                   mErr_q;

    logic                   hit_d;
    logic [SW-1:0]          hitIdx_d;
    logic [AW-1:0]          offset_d;
    logic [N_SLAVES-1:0]    selOneHot_d;
    logic                   selValid;
    logic [DW-1:0]          selData;

    // Walk from the highest index down so the lowest matching slave wins overlaps.
    always_comb begin
        hit_d    = 1'b0;
        hitIdx_d = '0;
        offset_d = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit_d    = 1'b1;
                hitIdx_d = SW'(i);
                offset_d = m_addr & ~MASK[i*AW +: AW];
            end
        end
    end

    always_comb begin
        selOneHot_d           = '0;
        selOneHot_d[hitIdx_d] = 1'b1;
    end

    assign selValid     = s_rd_valid[sel_q];
    assign selData      = s_rd_data[sel_q*DW +: DW];
    assign timeoutCnt_d = timeoutCnt_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            isRd_q       <= 1'b0;
            timeoutCnt_q <= '0;
            sAddr_q      <= '0;
            sWrData_q    <= '0;
            sWrMask_q    <= '0;
            sRdEn_q      <= '0;
            sWrEn_q      <= '0;
            mRdData_q    <= '0;
            mRdValid_q   <= 1'b0;
            mErr_q       <= 1'b0;
        end else begin
            sRdEn_q    <= '0;
            sWrEn_q    <= '0;
            mRdValid_q <= 1'b0;
            mErr_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_rd_en || m_wr_en) begin
                        isRd_q <= m_rd_en;
                        if (hit_d) begin
                            sel_q     <= hitIdx_d;
                            sAddr_q   <= offset_d;
                            sWrData_q <= m_wr_data;
                            sWrMask_q <= m_wr_mask;
                            if (m_rd_en) begin
                                sRdEn_q <= selOneHot_d;
                            end else begin
                                sWrEn_q <= selOneHot_d;
                            end
                            state_q <= ISSUE;
                        end else begin
                            mErr_q <= 1'b1;
                            if (m_rd_en) begin
                                mRdValid_q <= 1'b1;
                                mRdData_q  <= ERR_DATA;
                            end
                            state_q <= RESP;
                        end
                    end
                end
                // A slave may answer in the same cycle it sees its strobe.
                ISSUE: begin
                    timeoutCnt_q <= '0;
                    if (!isRd_q) begin
                        state_q <= IDLE;
                    end else if (selValid) begin
                        mRdData_q  <= selData;
                        mRdValid_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (selValid) begin
                        mRdData_q    <= selData;
                        mRdValid_q   <= 1'b1;
                        timeoutCnt_q <= '0;
                        state_q      <= RESP;
                    end else if (timeoutCnt_d == 16'(TIMEOUT)) begin
                        mRdData_q    <= ERR_DATA;
                        mRdValid_q   <= 1'b1;
                        mErr_q       <= 1'b1;
                        timeoutCnt_q <= '0;
                        state_q      <= RESP;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_busy     = (state_q != IDLE);
    assign m_rd_data  = mRdData_q;
    assign m_rd_valid = mRdValid_q;
    assign m_err      = mErr_q;
    assign s_addr     = sAddr_q;
    assign s_wr_data  = sWrData_q;
    assign s_wr_mask  = sWrMask_q;
    assign s_rd_en    = sRdEn_q;
    assign s_wr_en    = sWrEn_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: stimulus pushes expected strobes and responses,
// a monitor pops and compares them against what the fabric actually presents.
module tb_bus_fabric;

    localparam int             AW       = 16;
    localparam int             DW       = 32;
    localparam int             NS       = 4;
    localparam int             TIMEOUT  = 8;
    localparam logic [DW-1:0]  ERR_DATA = 32'hDEADBEEF;
    localparam logic [NS*AW-1:0] BASE = {16'h8000, 16'h4000, 16'h4000, 16'h0000};
    localparam logic [NS*AW-1:0] MASK = {16'h8000, 16'hE000, 16'hF000, 16'hC000};

    typedef struct {
        int          cyc;
        bit          isRead;
        logic [31:0] data;
        bit          err;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } strobe_t;

    logic           clk;
    logic           rst_n;
    logic [AW-1:0]  m_addr;
    logic           m_rd_en;
    logic           m_wr_en;
    logic [DW-1:0]  m_wr_data;
    logic [3:0]     m_wr_mask;
    logic [DW-1:0]  m_rd_data;
    logic           m_rd_valid;
    logic           m_busy;
    logic           m_err;
    logic [AW-1:0]  s_addr;
    logic [DW-1:0]  s_wr_data;
    logic [3:0]     s_wr_mask;
    logic [NS-1:0]  s_rd_en;
    logic [NS-1:0]  s_wr_en;
    logic [NS*DW-1:0] s_rd_data;
    logic [NS-1:0]  s_rd_valid;

    resp_t   respQ[$];
    strobe_t strobeQ[$];
    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      busyFrom = 1;
    int      busyTo = 0;
    logic [31:0] refHeld = '0;

    // Address map as plain inclusive ranges, first match in index order wins.
    int regLo[4] = '{32'h0000, 32'h4000, 32'h4000, 32'h8000};
    int regHi[4] = '{32'h3FFF, 32'h4FFF, 32'h5FFF, 32'hFFFF};

    bus_fabric #(
        .AW(AW), .DW(DW), .N_SLAVES(NS), .BASE(BASE), .MASK(MASK),
        .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_addr(m_addr), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
        .m_wr_data(m_wr_data), .m_wr_mask(m_wr_mask),
        .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_busy(m_busy), .m_err(m_err),
        .s_addr(s_addr), .s_wr_data(s_wr_data), .s_wr_mask(s_wr_mask),
        .s_rd_en(s_rd_en), .s_wr_en(s_wr_en),
        .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int refSlave(input logic [15:0] addr);
        int a;
        a = int'(addr);
        for (int i = 0; i < 4; i++) begin
            if (a >= regLo[i] && a <= regHi[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic randomSlaveData();
        s_rd_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            m_rd_en = 1'b0;
            m_wr_en = 1'b0;
            m_addr = 16'($urandom);
            s_rd_valid = 4'($urandom);
            randomSlaveData();
        end
    endtask

    // One complete transaction; returns on the last busy cycle so calls can run back-to-back.
    task automatic applyStimulus(input bit isRead, input logic [15:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wmask, input int k, input logic [31:0] rdata,
                                 input bit spurious);
        int sel;
        int t0;
        int doneCyc;
        int hitCyc;
        logic [3:0] oneHot;
        resp_t r;
        strobe_t s;
        sel = refSlave(addr);
        oneHot = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
        hitCyc = -1;
        @(negedge clk);
        t0 = cyc;
        m_addr = addr;
        m_rd_en = isRead;
        m_wr_en = !isRead;
        m_wr_data = wdata;
        m_wr_mask = wmask;
        s_rd_valid = 4'($urandom);
        randomSlaveData();
        if (sel < 0) begin
            r.cyc = t0 + 1;
            r.isRead = isRead;
            r.data = ERR_DATA;
            r.err = 1'b1;
            respQ.push_back(r);
            doneCyc = t0 + 2;
        end else begin
            s.cyc = t0 + 1;
            s.rd = isRead ? oneHot : 4'b0000;
            s.wr = isRead ? 4'b0000 : oneHot;
            s.addr = 16'(int'(addr) - regLo[sel]);
            s.data = wdata;
            s.mask = wmask;
            strobeQ.push_back(s);
            if (!isRead) begin
                doneCyc = t0 + 2;
            end else begin
                r.isRead = 1'b1;
                if (k >= 0 && k <= TIMEOUT) begin
                    r.cyc = t0 + 2 + k;
                    r.data = rdata;
                    r.err = 1'b0;
                    hitCyc = t0 + 1 + k;
                    doneCyc = t0 + 3 + k;
                end else begin
                    r.cyc = t0 + 2 + TIMEOUT;
                    r.data = ERR_DATA;
                    r.err = 1'b1;
                    if (k >= 0) hitCyc = t0 + 1 + k;
                    doneCyc = t0 + 3 + TIMEOUT;
                end
                respQ.push_back(r);
            end
        end
        busyFrom = t0 + 1;
        busyTo = doneCyc - 1;
        for (int c = t0 + 1; c < doneCyc; c++) begin
            @(negedge clk);
            m_rd_en = 1'b0;
            m_wr_en = 1'b0;
            m_addr = 16'($urandom);
            m_wr_data = $urandom;
            if (spurious && c == t0 + 1) begin
                if ($urandom_range(0, 1) == 1) m_rd_en = 1'b1;
                else m_wr_en = 1'b1;
            end
            randomSlaveData();
            if (isRead && sel >= 0) s_rd_valid = 4'($urandom) & ~oneHot;
            else s_rd_valid = 4'($urandom);
            if (c == hitCyc) begin
                s_rd_valid[sel] = 1'b1;
                s_rd_data[sel*32 +: 32] = rdata;
            end
        end
    endtask

    // Abort an outstanding read with an asynchronous reset.
    task automatic applyResetMidRead();
        int t0;
        strobe_t s;
        @(negedge clk);
        t0 = cyc;
        m_addr = 16'h8004;
        m_rd_en = 1'b1;
        m_wr_en = 1'b0;
        s_rd_valid = 4'b0000;
        s.cyc = t0 + 1;
        s.rd = 4'b1000;
        s.wr = 4'b0000;
        s.addr = 16'h0004;
        s.data = m_wr_data;
        s.mask = m_wr_mask;
        strobeQ.push_back(s);
        busyFrom = t0 + 1;
        busyTo = t0 + 1000;
        @(negedge clk);
        m_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        busyTo = 0;
        checkOutput("rst_async_strobes", 64'({s_rd_en, s_wr_en}), 64'd0);
        checkOutput("rst_async_flags", 64'({m_rd_valid, m_err, m_busy}), 64'd0);
        checkOutput("rst_async_slave_regs", 64'({s_addr, s_wr_mask}), 64'd0);
        checkOutput("rst_async_wr_data", 64'(s_wr_data), 64'd0);
        s_rd_valid = 4'b1000;
        repeat (2) @(negedge clk);
        s_rd_valid = 4'b0000;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard queues.
    initial begin
        resp_t r;
        strobe_t s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                refHeld = '0;
            end else begin
                while (respQ.size() > 0 && respQ[0].cyc < cyc) begin
                    r = respQ.pop_front();
                    checks++;
                    failures++;
                    $display("[TB] FAIL resp_missing at cycle %0d: got nothing, expected response due at cycle %0d", cyc, r.cyc);
                end
                while (strobeQ.size() > 0 && strobeQ[0].cyc < cyc) begin
                    s = strobeQ.pop_front();
                    checks++;
                    failures++;
                    $display("[TB] FAIL strobe_missing at cycle %0d: got nothing, expected strobe due at cycle %0d", cyc, s.cyc);
                end
                if (m_rd_valid || m_err) begin
                    if (respQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL resp_unexpected at cycle %0d: got valid=%b err=%b, expected no response", cyc, m_rd_valid, m_err);
                    end else begin
                        r = respQ.pop_front();
                        checkOutput("resp_cycle", 64'(cyc), 64'(r.cyc));
                        checkOutput("resp_valid", 64'(m_rd_valid), 64'(r.isRead));
                        checkOutput("resp_err", 64'(m_err), 64'(r.err));
                        if (r.isRead) refHeld = r.data;
                    end
                end
                checkOutput("rd_data", 64'(m_rd_data), 64'(refHeld));
                if (s_rd_en != 4'b0000 || s_wr_en != 4'b0000) begin
                    if (strobeQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL strobe_unexpected at cycle %0d: got rd=%b wr=%b, expected none", cyc, s_rd_en, s_wr_en);
                    end else begin
                        s = strobeQ.pop_front();
                        checkOutput("strobe_cycle", 64'(cyc), 64'(s.cyc));
                        checkOutput("strobe_rd", 64'(s_rd_en), 64'(s.rd));
                        checkOutput("strobe_wr", 64'(s_wr_en), 64'(s.wr));
                        checkOutput("strobe_addr", 64'(s_addr), 64'(s.addr));
                        if (s.wr != 4'b0000) begin
                            checkOutput("strobe_wr_data", 64'(s_wr_data), 64'(s.data));
                            checkOutput("strobe_wr_mask", 64'(s_wr_mask), 64'(s.mask));
                        end
                    end
                end
                checkOutput("busy", 64'(m_busy), 64'(cyc >= busyFrom && cyc <= busyTo));
            end
        end
    end

    // Directed scenarios first, then randomized transactions.
    initial begin
        bit isRead;
        int k;
        rst_n = 1'b0;
        m_addr = '0;
        m_rd_en = 1'b0;
        m_wr_en = 1'b0;
        m_wr_data = '0;
        m_wr_mask = '0;
        s_rd_data = '0;
        s_rd_valid = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_flags", 64'({m_rd_valid, m_err, m_busy, s_rd_en, s_wr_en}), 64'd0);
        checkOutput("reset_rd_data", 64'(m_rd_data), 64'd0);
        checkOutput("reset_slave_regs", 64'({s_addr, s_wr_mask}), 64'd0);
        checkOutput("reset_wr_data", 64'(s_wr_data), 64'd0);
        rst_n = 1'b1;
        idleCycles(2);

        applyStimulus(1'b1, 16'h8004, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, 16'h0010, 32'h12345678, 4'b0011, 0, 32'h0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 16'h6000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 16'h7000, 32'h55AA55AA, 4'hF, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 16'h4123, 32'h0, 4'h0, -1, 32'h0, 1'b0);
        applyStimulus(1'b1, 16'h4124, 32'h0, 4'h0, TIMEOUT, 32'hA5A50F0F, 1'b0);
        applyStimulus(1'b1, 16'h4125, 32'h0, 4'h0, TIMEOUT + 1, 32'h11111111, 1'b0);
        applyStimulus(1'b1, 16'h8100, 32'h0, 4'h0, 0, 32'h13572468, 1'b0);
        applyStimulus(1'b1, 16'h4800, 32'h0, 4'h0, 1, 32'h0000BEEF, 1'b0);
        applyStimulus(1'b1, 16'h5800, 32'h0, 4'h0, 3, 32'h12121212, 1'b0);
        applyStimulus(1'b0, 16'h5004, 32'h87654321, 4'b1100, 0, 32'h0, 1'b1);
        applyStimulus(1'b1, 16'h8ABC, 32'h0, 4'h0, 4, 32'h0BADCAFE, 1'b1);
        applyResetMidRead();
        applyStimulus(1'b1, 16'h8004, 32'h0, 4'h0, 2, 32'h600DF00D, 1'b0);

        repeat (300) begin
            isRead = ($urandom_range(0, 1) == 1);
            k = $urandom_range(0, TIMEOUT + 3);
            if (k == TIMEOUT + 3) k = -1;
            applyStimulus(isRead, 16'($urandom), $urandom, 4'($urandom), k, $urandom,
                          ($urandom_range(0, 3) == 0));
            idleCycles($urandom_range(0, 2));
        end

        idleCycles(4);
        checkOutput("resp_queue_drained", 64'(respQ.size()), 64'd0);
        checkOutput("strobe_queue_drained", 64'(strobeQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
